// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock: FSM state encodings, key codes
// and the default entry timeout.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  localparam logic [3:0] NOKEY           = 4'd10;
  localparam logic [3:0] DIGIT_MAX       = 4'd9;
  localparam int unsigned TIMEOUT_DEFAULT = 10;

  // Codes above 9 (NOKEY and the unused 11-15) all count as "no key".
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/alarm_fsm_timer.sv
// Idle-seconds counter for key entry; flags the second that completes
// TIMEOUT_SECS idle seconds. Present only when ALARM_FSM_TIMEOUT_EN is set.
module alarm_fsm_timer
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic one_second,
  output logic timeout
);

  localparam int unsigned W = $clog2(TIMEOUT_SECS + 1);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT_SECS - 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_SECS);

  logic [W-1:0] count;

  // Saturates at TIMEOUT_SECS so a held key in KEY_WAITED cannot wrap it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && one_second && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = enable && one_second && (count == LAST);

endmodule

// File: rtl/alarm_fsm.sv
// Main alarm clock control FSM: digit entry, alarm/time load strobes and
// display select. Entry timeout is built only with ALARM_FSM_TIMEOUT_EN.
//
// state            | meaning
// SHOW_TIME        | idle, display shows current time
// SHOW_ALARM       | ALARM held, display shows stored alarm
// KEY_STORED       | shift accepted digit into key register
// KEY_WAITED       | wait for key release before next digit
// KEY_ENTRY        | await next digit or a confirming button
// SET_ALARM_TIME   | load entered digits into alarm register
// SET_CURRENT_TIME | load entered digits into time counter
module alarm_fsm
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_SECS = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_alarm,
  output logic       load_new_time,
  output logic       show_new_time,
  output logic       show_a
);

  state_t state, state_next;
  logic   timeout;
  logic   in_entry;

  assign in_entry = (state == KEY_WAITED) || (state == KEY_ENTRY);

`ifdef ALARM_FSM_TIMEOUT_EN
  alarm_fsm_timer #(
    .TIMEOUT_SECS(TIMEOUT_SECS)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (!in_entry),
    .enable    (in_entry),
    .one_second(one_second),
    .timeout   (timeout)
  );
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = one_second ^ in_entry ^ (TIMEOUT_SECS == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SHOW_TIME: begin
        if (alarm_button)       state_next = SHOW_ALARM;
        else if (is_digit(key)) state_next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) state_next = SHOW_TIME;
      end
      KEY_STORED: state_next = KEY_WAITED;
      KEY_WAITED: begin
        if (!is_digit(key)) state_next = KEY_ENTRY;
        else if (timeout)   state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        if (alarm_button)       state_next = SET_ALARM_TIME;
        else if (time_button)   state_next = SET_CURRENT_TIME;
        else if (is_digit(key)) state_next = KEY_STORED;
        else if (timeout)       state_next = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_next = SHOW_TIME;
      SET_CURRENT_TIME: state_next = SHOW_TIME;
      default:          state_next = SHOW_TIME;
    endcase
  end

  always_comb begin
    shift          = 1'b0;
    load_new_alarm = 1'b0;
    load_new_time  = 1'b0;
    show_new_time  = 1'b0;
    show_a         = 1'b0;
    case (state)
      SHOW_ALARM:       show_a         = 1'b1;
      KEY_STORED:       shift          = 1'b1;
      KEY_WAITED:       show_new_time  = 1'b1;
      KEY_ENTRY:        show_new_time  = 1'b1;
      SET_ALARM_TIME:   load_new_alarm = 1'b1;
      SET_CURRENT_TIME: load_new_time  = 1'b1;
      default:          ;
    endcase
  end

endmodule
